// File: rtl/allpass_cfg_pkg.sv
// Shared types, constants and helpers for the all-pass configuration loader.
// FIXED_POINT / MAX_FILTER_FIFO_LENGTH fall back to local defaults when constants.svh is absent.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 1024
`endif

package allpass_cfg_pkg;

  typedef enum logic [1:0] {StIdle, StPend, StSetup, StStrobe} state_e;

  typedef enum logic {FldTau = 1'b0, FldGain = 1'b1} field_e;

  localparam int unsigned FIXED_POINT = `FIXED_POINT;
  localparam int          TAU_MIN     = 1;
  localparam int          TAU_MAX     = `MAX_FILTER_FIFO_LENGTH;
  // Largest gain strictly below 1.0 in the fixed-point format.
  localparam int          GAIN_MAX    = (1 << FIXED_POINT) - 1;

  function automatic int unsigned word_width(input int unsigned width);
    return width + FIXED_POINT;
  endfunction

endpackage

// File: rtl/cfg_saturate.sv
// Combinational clamp of a host write into the legal range for its field.
module cfg_saturate
  import allpass_cfg_pkg::*;
#(
  parameter int unsigned WORD = 32
) (
  input  field_e            field,
  input  logic [WORD-1:0]   data,
  output logic [WORD-1:0]   value,
  output logic              sat
);

  localparam logic signed [WORD-1:0] TauLo  = WORD'(TAU_MIN);
  localparam logic signed [WORD-1:0] TauHi  = WORD'(TAU_MAX);
  localparam logic signed [WORD-1:0] GainHi = WORD'(GAIN_MAX);
  localparam logic signed [WORD-1:0] GainLo = -GainHi;

  logic signed [WORD-1:0] sdata;
  logic signed [WORD-1:0] lo;
  logic signed [WORD-1:0] hi;

  assign sdata = signed'(data);

  always_comb begin
    lo    = (field == FldGain) ? GainLo : TauLo;
    hi    = (field == FldGain) ? GainHi : TauHi;
    value = data;
    sat   = 1'b0;
    if (sdata < lo) begin
      value = lo;
      sat   = 1'b1;
    end else if (sdata > hi) begin
      value = hi;
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/allpass_cfg_loader.sv
// Shadow-register loader that commits tau/gain to the all-pass bank on a sample boundary.
// Optional readback port enabled by defining ALLPASS_CFG_READBACK_EN.
module allpass_cfg_loader
  import allpass_cfg_pkg::*;
#(
  parameter int unsigned WIDTH         = 24,
  parameter int unsigned N_FILTERS     = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  localparam int unsigned WORD         = word_width(WIDTH),
  localparam int unsigned AW           = $clog2(N_FILTERS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [AW-1:0]               cfg_addr,
  input  logic [WORD-1:0]             cfg_data,
  input  logic                        cfg_commit,
  output logic [N_FILTERS*WORD-1:0]   tau_out,
  output logic [N_FILTERS*WORD-1:0]   gain_out,
  output logic [N_FILTERS-1:0]        write_out,
  output logic                        busy,
  output logic                        err_sat
`ifdef ALLPASS_CFG_READBACK_EN
  ,
  input  logic [AW-1:0]               rd_addr,
  output logic [WORD-1:0]             rd_data
`endif
);

  localparam int unsigned CntW = $clog2(STROBE_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            commit_pend_q, commit_pend_d;
  logic            err_sat_q;
  logic            strobe_last;
  logic            load_live;

  logic [WORD-1:0] tau_sh_q [N_FILTERS];
  logic [WORD-1:0] gain_sh_q[N_FILTERS];
  logic [WORD-1:0] tau_sh_d [N_FILTERS];
  logic [WORD-1:0] gain_sh_d[N_FILTERS];
  logic [WORD-1:0] tau_q    [N_FILTERS];
  logic [WORD-1:0] gain_q   [N_FILTERS];

  logic [AW-1:0]   wr_idx;
  field_e          wr_field;
  logic            wr_en;
  logic [WORD-1:0] sat_value;
  logic            sat_flag;

  assign wr_idx   = cfg_addr >> 1;
  assign wr_field = field_e'(cfg_addr[0]);
  // Out-of-range indices are silently dropped.
  assign wr_en    = cfg_valid && cfg_ready && (32'(wr_idx) < N_FILTERS);

  cfg_saturate #(
    .WORD (WORD)
  ) u_sat (
    .field (wr_field),
    .data  (cfg_data),
    .value (sat_value),
    .sat   (sat_flag)
  );

  assign strobe_last = (state_q == StStrobe) && (cnt_q == CntW'(STROBE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      commit_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= (state_q == StStrobe) ? cnt_q + CntW'(1) : '0;
      commit_pend_q <= commit_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    commit_pend_d = commit_pend_q;
    unique case (state_q)
      StIdle:   if (cfg_commit) state_d = StPend;
      StPend:   if (sample_tick) state_d = StSetup;
      StSetup: begin
        state_d = StStrobe;
        if (cfg_commit) commit_pend_d = 1'b1;
      end
      StStrobe: begin
        if (cfg_commit) commit_pend_d = 1'b1;
        if (strobe_last) begin
          state_d       = (commit_pend_q || cfg_commit) ? StPend : StIdle;
          commit_pend_d = 1'b0;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == StIdle) || (state_q == StPend);
    busy      = (state_q != StIdle);
    write_out = {N_FILTERS{state_q == StStrobe}};
    load_live = (state_q == StPend) && sample_tick;
  end

  // Snapshot uses the next shadow value so a write in the tick cycle is included.
  always_comb begin
    for (int unsigned i = 0; i < N_FILTERS; i++) begin
      tau_sh_d[i]  = tau_sh_q[i];
      gain_sh_d[i] = gain_sh_q[i];
      if (wr_en && (32'(wr_idx) == i)) begin
        if (wr_field == FldGain) gain_sh_d[i] = sat_value;
        else                     tau_sh_d[i]  = sat_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sat_q <= 1'b0;
      for (int unsigned i = 0; i < N_FILTERS; i++) begin
        tau_sh_q[i]  <= WORD'(TAU_MIN);
        gain_sh_q[i] <= '0;
        tau_q[i]     <= WORD'(TAU_MIN);
        gain_q[i]    <= '0;
      end
    end else begin
      err_sat_q <= err_sat_q | (wr_en & sat_flag);
      tau_sh_q  <= tau_sh_d;
      gain_sh_q <= gain_sh_d;
      if (load_live) begin
        tau_q  <= tau_sh_d;
        gain_q <= gain_sh_d;
      end
    end
  end

  assign err_sat = err_sat_q;

  for (genvar g = 0; g < N_FILTERS; g++) begin : g_pack
    assign tau_out[g*WORD +: WORD]  = tau_q[g];
    assign gain_out[g*WORD +: WORD] = gain_q[g];
  end

`ifdef ALLPASS_CFG_READBACK_EN
  logic [AW-1:0]   rd_addr_q;
  logic [AW-1:0]   rd_idx;
  logic [WORD-1:0] rd_val;
  logic [WORD-1:0] rd_data_q;

  assign rd_idx = rd_addr_q >> 1;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < N_FILTERS; i++) begin
      if (32'(rd_idx) == i) rd_val = rd_addr_q[0] ? gain_q[i] : tau_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_addr_q <= rd_addr;
      rd_data_q <= rd_val;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule
